// File: rtl/tcp_decoder_pkg.sv
// Shared definitions for the TCP segment decoder and its checksum helper.
package tcp_decoder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    OPT  = 3'd2,
    PAY  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [15:0] TCP_PROTO = 16'd6;
  localparam logic [3:0]  MIN_DOFF  = 4'd5;

  // Header word indices within a segment
  localparam logic [2:0] W_PORTS = 3'd0;
  localparam logic [2:0] W_SEQ   = 3'd1;
  localparam logic [2:0] W_ACK   = 3'd2;
  localparam logic [2:0] W_CTRL  = 3'd3;
  localparam logic [2:0] W_CSUM  = 3'd4;

  // Two end-around-carry folds bring any 32-bit sum into 16 bits without overflow
  function automatic logic [HALF_W-1:0] csum_fold(input logic [WORD_W-1:0] sum);
    logic [16:0] f1;
    logic [15:0] f2;
    f1 = 17'(sum[31:16]) + 17'(sum[15:0]);
    f2 = f1[15:0] + 16'(f1[16]);
    return f2;
  endfunction

endpackage

// File: rtl/tcp_csum_acc.sv
// Ones'-complement checksum accumulator: seed load, per-word add, folded view of the next sum.
module tcp_csum_acc
  import tcp_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              add_en,
  input  logic [WORD_W-1:0] seed,
  input  logic [WORD_W-1:0] word,
  output logic [HALF_W-1:0] fold_c
);

  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_base;
  logic [WORD_W-1:0] acc_nxt;

  always_comb begin
    acc_base = load ? seed : acc;
    acc_nxt  = acc_base;
    if (add_en) begin
      acc_nxt = acc_base + 32'(word[31:16]) + 32'(word[15:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

  // Fold includes the word being accepted so the verdict can register with it
  assign fold_c = csum_fold(acc_nxt);

endmodule

// File: rtl/tcp_decoder.sv
// TCP segment decoder: parses the header, forwards options/payload, verifies the checksum.
module tcp_decoder
  import tcp_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  input  logic        data_av,
  input  logic        start,
  input  logic [15:0] len,
  input  logic [31:0] src_ip,
  input  logic [31:0] dest_ip,
  output logic [15:0] src_port,
  output logic [15:0] dest_port,
  output logic [31:0] seq_num,
  output logic [31:0] ack_num,
  output logic        f_urg,
  output logic        f_ack,
  output logic        f_psh,
  output logic        f_rst,
  output logic        f_syn,
  output logic        f_fin,
  output logic [15:0] window,
  output logic [15:0] urg_ptr,
  output logic [15:0] checksum,
  output logic [3:0]  opt_word,
  output logic        hdr_valid,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_opt,
  output logic        out_last,
  output logic [1:0]  out_bytes,
  output logic        fin,
  output logic        chk_ok,
  output logic        err
);

  state_t      state;
  state_t      state_nxt;
  state_t      pay_route;
  state_t      hdr_route;

  logic [15:0] len_r;
  logic [2:0]  hdr_idx;
  logic [3:0]  doff_r;
  logic [3:0]  opt_cnt;
  logic [14:0] pay_cnt;
  logic [1:0]  pay_rem;

  logic [15:0] hdr_bytes;
  logic [15:0] pay_len;
  logic [14:0] pay_words;
  logic        hdr_bad;

  logic        restart;
  logic        hdr_word;
  logic        fwd_opt;
  logic        fwd_pay;
  logic        err_set;
  logic        csum_add;
  logic [31:0] csum_seed;
  logic [15:0] csum_fold_c;

  assign restart  = data_av & start;
  assign csum_add = restart | hdr_word | fwd_opt | fwd_pay;

  assign csum_seed = 32'(src_ip[31:16]) + 32'(src_ip[15:0]) +
                     32'(dest_ip[31:16]) + 32'(dest_ip[15:0]) +
                     32'(TCP_PROTO) + 32'(len);

  tcp_csum_acc u_csum (
    .clk    (clk),
    .reset  (reset),
    .load   (restart),
    .add_en (csum_add),
    .seed   (csum_seed),
    .word   (data),
    .fold_c (csum_fold_c)
  );

  // Segment geometry derived from the captured offset and length
  always_comb begin
    hdr_bytes = {10'd0, doff_r, 2'b00};
    pay_len   = len_r - hdr_bytes;
    pay_words = 15'((17'(pay_len) + 17'd3) >> 2);
    hdr_bad   = (doff_r < MIN_DOFF) || (hdr_bytes > len_r);
    pay_route = (pay_len != 16'd0) ? PAY : DONE;
    if (hdr_bad) begin
      hdr_route = DONE;
    end else if (doff_r > MIN_DOFF) begin
      hdr_route = OPT;
    end else begin
      hdr_route = pay_route;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A start word in any state restarts the parse; DONE lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    hdr_word  = 1'b0;
    fwd_opt   = 1'b0;
    fwd_pay   = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (restart) state_nxt = HDR;
      end
      HDR: begin
        if (restart) begin
          state_nxt = HDR;
        end else if (data_av) begin
          hdr_word = 1'b1;
          if (hdr_idx == W_CSUM) begin
            state_nxt = hdr_route;
            err_set   = hdr_bad;
          end
        end
      end
      OPT: begin
        if (restart) begin
          state_nxt = HDR;
        end else if (data_av) begin
          fwd_opt = 1'b1;
          if (opt_cnt == 4'd1) state_nxt = pay_route;
        end
      end
      PAY: begin
        if (restart) begin
          state_nxt = HDR;
        end else if (data_av) begin
          fwd_pay = 1'b1;
          if (pay_cnt == 15'd1) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = restart ? HDR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_r     <= '0;
      hdr_idx   <= W_PORTS;
      doff_r    <= '0;
      opt_cnt   <= '0;
      pay_cnt   <= '0;
      pay_rem   <= '0;
      src_port  <= '0;
      dest_port <= '0;
      seq_num   <= '0;
      ack_num   <= '0;
      {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin} <= '0;
      window    <= '0;
      urg_ptr   <= '0;
      checksum  <= '0;
      opt_word  <= '0;
      hdr_valid <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_opt   <= 1'b0;
      out_last  <= 1'b0;
      out_bytes <= '0;
      fin       <= 1'b0;
      chk_ok    <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= fwd_opt | fwd_pay;
      out_opt   <= fwd_opt;
      out_last  <= fwd_pay && (pay_cnt == 15'd1);
      out_bytes <= (fwd_pay && (pay_cnt == 15'd1)) ? pay_rem : 2'd0;
      fin       <= (state_nxt == DONE);
      if (fwd_opt | fwd_pay) out_data <= data;

      if (restart) begin
        len_r     <= len;
        src_port  <= data[31:16];
        dest_port <= data[15:0];
        hdr_idx   <= W_SEQ;
        hdr_valid <= 1'b0;
        chk_ok    <= 1'b0;
        err       <= 1'b0;
      end else if (hdr_word) begin
        hdr_idx <= hdr_idx + 3'd1;
        case (hdr_idx)
          W_SEQ: seq_num <= data;
          W_ACK: ack_num <= data;
          W_CTRL: begin
            doff_r <= data[31:28];
            {f_urg, f_ack, f_psh, f_rst, f_syn, f_fin} <= data[21:16];
            window   <= data[15:0];
            opt_word <= (data[31:28] > MIN_DOFF) ? data[31:28] - MIN_DOFF : 4'd0;
          end
          W_CSUM: begin
            checksum  <= data[31:16];
            urg_ptr   <= data[15:0];
            hdr_valid <= 1'b1;
            err       <= hdr_bad;
            opt_cnt   <= doff_r - MIN_DOFF;
            pay_cnt   <= pay_words;
            pay_rem   <= pay_len[1:0];
          end
          default: ;
        endcase
      end

      if (fwd_opt) opt_cnt <= opt_cnt - 4'd1;
      if (fwd_pay) pay_cnt <= pay_cnt - 15'd1;

      // Verdict registers together with the fin pulse on entry to DONE
      if (state_nxt == DONE) chk_ok <= (csum_fold_c == 16'hFFFF) && !err_set;
    end
  end

endmodule
